// File: rtl/header_inserter_if.sv
// Avalon-ST streaming bus used by header_inserter: first byte of a beat in the MSBs,
// empty counts invalid bytes on the eop beat.
interface avalon_st_if #(
  parameter int unsigned DATA_WIDTH = 128
);
  localparam int unsigned W       = DATA_WIDTH / 8;
  localparam int unsigned EMPTY_W = (W > 1) ? $clog2(W) : 1;

  logic                  sop;
  logic                  eop;
  logic [DATA_WIDTH-1:0] data;
  logic [EMPTY_W-1:0]    empty;
  logic                  valid;
  logic                  ready;

  modport master (output sop, eop, data, empty, valid, input ready);
  modport slave  (input sop, eop, data, empty, valid, output ready);
endinterface

// File: rtl/header_inserter.sv
// Prepends a runtime-length header to each Avalon-ST packet and byte-realigns the payload
// through a carry register. Optional input sop checking under HEADER_INSERTER_PROTO_CHK_EN.
module header_inserter #(
  parameter int unsigned DATA_WIDTH       = 128,
  parameter int unsigned MAX_HEADER_BYTES = 64
) (
  input  logic                                  clk,
  input  logic                                  rst,
  avalon_st_if.slave                            data_in,
  input  logic [MAX_HEADER_BYTES*8-1:0]         header_data,
  input  logic [$clog2(MAX_HEADER_BYTES+1)-1:0] header_len,
  input  logic                                  header_vld,
  output logic                                  header_ack,
  avalon_st_if.master                           data_out,
  output logic                                  proto_err
);
  localparam int unsigned W       = DATA_WIDTH / 8;
  localparam int unsigned EMPTY_W = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned LEN_W   = $clog2(MAX_HEADER_BYTES + 1);
  localparam int unsigned HDR_W   = MAX_HEADER_BYTES * 8;

  typedef enum logic [2:0] {S_IDLE, S_HEADER, S_PASS, S_MERGE, S_FLUSH} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [HDR_W-1:0]      r_hdr;
  logic [LEN_W-1:0]      r_f;
  logic [LEN_W-1:0]      r_r;
  logic [LEN_W-1:0]      r_wcnt;
  logic [DATA_WIDTH-1:0] r_carry;
  logic [EMPTY_W-1:0]    r_flush_empty;
  logic                  r_out_first;

  logic [LEN_W-1:0]      w_len;
  int unsigned           w_f_i;
  int unsigned           w_r_i;
  int unsigned           w_ri;
  int unsigned           w_v;
  logic [DATA_WIDTH-1:0] w_hdr_carry;
  logic [DATA_WIDTH-1:0] w_hdr_word;
  logic [DATA_WIDTH-1:0] w_in_masked;
  logic [DATA_WIDTH-1:0] w_merge_data;
  logic                  w_in_acc;
  logic                  w_out_acc;

  // Mask with the top n bytes set; n >= W gives all ones, n == 0 gives zero.
  function automatic logic [DATA_WIDTH-1:0] top_bytes_mask(input int unsigned n);
    return ~({DATA_WIDTH{1'b1}} >> (n * 8));
  endfunction

  assign w_len = (header_len > LEN_W'(MAX_HEADER_BYTES)) ? LEN_W'(MAX_HEADER_BYTES) : header_len;
  assign w_f_i = 32'(w_len) / W;
  assign w_r_i = 32'(w_len) % W;
  assign w_ri  = 32'(r_r);
  assign w_v   = (32'(data_in.empty) >= W) ? 32'd0 : W - 32'(data_in.empty);

  // Header tail bytes F*W..L-1, left-justified, seed the carry for the first payload beat.
  assign w_hdr_carry = DATA_WIDTH'(({header_data, {DATA_WIDTH{1'b0}}} << (w_f_i * W * 8)) >> HDR_W)
                       & top_bytes_mask(w_r_i);
  assign w_hdr_word  = DATA_WIDTH'(({r_hdr, {DATA_WIDTH{1'b0}}} << (32'(r_wcnt) * W * 8)) >> HDR_W);

  // Invalid bytes of an eop beat are zeroed so they never leak into the output or carry.
  assign w_in_masked  = data_in.eop ? (data_in.data & top_bytes_mask(w_v)) : data_in.data;
  assign w_merge_data = r_carry | (w_in_masked >> (w_ri * 8));

  assign w_in_acc  = data_in.valid & data_in.ready;
  assign w_out_acc = data_out.valid & data_out.ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_hdr         <= '0;
      r_f           <= '0;
      r_r           <= '0;
      r_wcnt        <= '0;
      r_carry       <= '0;
      r_flush_empty <= '0;
      r_out_first   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_out_acc) r_out_first <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (header_vld) begin
            r_hdr       <= header_data;
            r_f         <= LEN_W'(w_f_i);
            r_r         <= LEN_W'(w_r_i);
            r_wcnt      <= '0;
            r_carry     <= w_hdr_carry;
            r_out_first <= 1'b1;
          end
        end
        S_HEADER: if (w_out_acc) r_wcnt <= r_wcnt + LEN_W'(1);
        S_MERGE: begin
          if (w_in_acc) begin
            r_carry <= w_in_masked << ((W - w_ri) * 8);
            if (data_in.eop) r_flush_empty <= EMPTY_W'(2 * W - w_ri - w_v);
          end
        end
        default: ;
      endcase
    end
  end

  // Next state and stream outputs; payload paths are combinational through data_in.
  always_comb begin
    w_next         = r_state;
    header_ack     = 1'b0;
    data_out.valid = 1'b0;
    data_out.sop   = 1'b0;
    data_out.eop   = 1'b0;
    data_out.data  = '0;
    data_out.empty = '0;
    data_in.ready  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (header_vld) begin
          header_ack = 1'b1;
          if (w_f_i > 0)      w_next = S_HEADER;
          else if (w_r_i > 0) w_next = S_MERGE;
          else                w_next = S_PASS;
        end
      end
      S_HEADER: begin
        data_out.valid = 1'b1;
        data_out.sop   = r_out_first;
        data_out.data  = w_hdr_word;
        if (data_out.ready && (r_wcnt == r_f - LEN_W'(1)))
          w_next = (r_r != '0) ? S_MERGE : S_PASS;
      end
      S_PASS: begin
        data_out.valid = data_in.valid;
        data_in.ready  = data_out.ready;
        data_out.sop   = r_out_first;
        data_out.eop   = data_in.eop;
        data_out.data  = w_in_masked;
        data_out.empty = data_in.eop ? data_in.empty : '0;
        if (data_in.valid && data_out.ready && data_in.eop) w_next = S_IDLE;
      end
      S_MERGE: begin
        data_out.valid = data_in.valid;
        data_in.ready  = data_out.ready;
        data_out.sop   = r_out_first;
        data_out.data  = w_merge_data;
        if (data_in.eop) begin
          if (w_v <= W - w_ri) begin
            data_out.eop   = 1'b1;
            data_out.empty = EMPTY_W'(W - w_ri - w_v);
            if (data_in.valid && data_out.ready) w_next = S_IDLE;
          end else if (data_in.valid && data_out.ready) begin
            w_next = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        data_out.valid = 1'b1;
        data_out.eop   = 1'b1;
        data_out.data  = r_carry;
        data_out.empty = r_flush_empty;
        if (data_out.ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (rst) begin
      header_ack     = 1'b0;
      data_out.valid = 1'b0;
      data_in.ready  = 1'b0;
    end
  end

`ifdef HEADER_INSERTER_PROTO_CHK_EN
  logic r_in_first;
  logic r_proto_err;

  // Flags a missing sop on the first payload beat or a stray sop on a later one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_first  <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_proto_err <= w_in_acc && (r_in_first ? !data_in.sop : data_in.sop);
      if (r_state == S_IDLE && header_vld) r_in_first <= 1'b1;
      else if (w_in_acc)                   r_in_first <= 1'b0;
    end
  end
  assign proto_err = r_proto_err;
`else
  logic w_unused_sop;
  assign w_unused_sop = data_in.sop;
  assign proto_err    = 1'b0;
`endif

endmodule

// File: tb/tb_header_inserter.sv
// Directed and randomized checks of header_inserter at W=4, compared against a
// byte-stream model (header bytes followed by payload bytes, chopped into beats).
module tb_header_inserter;
  localparam int DW   = 32;
  localparam int W    = 4;
  localparam int MAXH = 16;
  localparam int LW   = $clog2(MAXH + 1);

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [1:0]    empty;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [MAXH*8-1:0] header_data = '0;
  logic [LW-1:0]   header_len = '0;
  logic            header_vld = 1'b0;
  logic            header_ack;
  logic            proto_err;

  avalon_st_if #(.DATA_WIDTH(DW)) din ();
  avalon_st_if #(.DATA_WIDTH(DW)) dout ();

  header_inserter #(.DATA_WIDTH(DW), .MAX_HEADER_BYTES(MAXH)) dut (
    .clk(clk), .rst(rst), .data_in(din), .header_data(header_data),
    .header_len(header_len), .header_vld(header_vld), .header_ack(header_ack),
    .data_out(dout), .proto_err(proto_err));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] hdr_b[MAXH];
  int         len_cfg;
  logic [7:0] pay_q[$];
  int         rdy_mode;
  int         gap_mode;
  bit         force_sop_err;

  beat_t o_q[$];
  bit    o_inrdy[$];
  beat_t exp_q[$];
  int    acks, stall_viol, first_cyc, perr_cnt;
  bit    timed_out, post_valid;

  task automatic load_header();
    for (int i = 0; i < MAXH; i++)
      header_data[MAXH*8-1-8*i -: 8] = (i < len_cfg) ? hdr_b[i] : 8'($urandom);
    header_len = LW'(len_cfg);
  endtask

  // Model: clamp L, concatenate header and payload bytes, cut into W-byte beats.
  function automatic void build_exp();
    logic [7:0] s[$];
    int l, n;
    exp_q.delete();
    l = (len_cfg > MAXH) ? MAXH : len_cfg;
    for (int i = 0; i < l; i++) s.push_back(hdr_b[i]);
    foreach (pay_q[i]) s.push_back(pay_q[i]);
    n = (s.size() + W - 1) / W;
    for (int b = 0; b < n; b++) begin
      beat_t e;
      int v;
      e = '0; v = 0;
      for (int k = 0; k < W; k++)
        if (b*W + k < s.size()) begin e.data[DW-1-8*k -: 8] = s[b*W+k]; v++; end
      e.sop   = (b == 0);
      e.eop   = (b == n - 1);
      e.empty = (b == n - 1) ? 2'(W - v) : 2'd0;
      exp_q.push_back(e);
    end
  endfunction

  // Drives one header plus payload packet and records every accepted output beat.
  task automatic run_packet();
    logic [DW-1:0] bd[$];
    int be[$];
    int nb, bi;
    bit done, hold, stalled;
    beat_t s_beat, cur;
    nb = (pay_q.size() + W - 1) / W;
    for (int b = 0; b < nb; b++) begin
      logic [DW-1:0] w;
      int e;
      w = '0; e = 0;
      for (int k = 0; k < W; k++) begin
        if (b*W + k < pay_q.size()) w[DW-1-8*k -: 8] = pay_q[b*W+k];
        else begin w[DW-1-8*k -: 8] = 8'hEE; e++; end
      end
      bd.push_back(w); be.push_back(e);
    end
    o_q.delete(); o_inrdy.delete();
    acks = 0; stall_viol = 0; first_cyc = -1; perr_cnt = 0;
    @(posedge clk); #1;
    load_header();
    header_vld = 1'b1;
    din.valid = 1'b0;
    dout.ready = 1'b1;
    @(negedge clk);
    if (header_ack) acks++;
    if (proto_err) perr_cnt++;
    @(posedge clk); #1;
    header_vld = 1'b0;
    header_data = {MAXH{8'h5A}};
    bi = 0; hold = 0; stalled = 0; done = 0; s_beat = '0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      if (cyc > 0) begin @(posedge clk); #1; end
      if (!hold) begin
        if (bi < nb && (gap_mode == 0 || $urandom_range(0, 2) != 0)) begin
          din.valid = 1'b1;
          din.data  = bd[bi];
          din.sop   = (bi == 0) || (force_sop_err && bi == 1);
          din.eop   = (bi == nb - 1);
          din.empty = 2'(be[bi]);
        end else begin
          din.valid = 1'b0;
          din.data  = $urandom;
          din.sop   = 1'b0;
          din.eop   = 1'b0;
          din.empty = 2'd0;
        end
      end
      dout.ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      @(negedge clk);
      cur = '{dout.data, dout.sop, dout.eop, dout.empty};
      if (header_ack) acks++;
      if (proto_err) perr_cnt++;
      if (first_cyc < 0 && dout.valid) first_cyc = cyc;
      if (stalled && (!dout.valid || cur !== s_beat)) stall_viol++;
      stalled = dout.valid && !dout.ready;
      s_beat = cur;
      if (dout.valid && dout.ready) begin
        o_q.push_back(cur);
        o_inrdy.push_back(din.ready);
        if (dout.eop) done = 1;
      end
      hold = din.valid && !din.ready;
      if (din.valid && din.ready) bi++;
    end
    timed_out = !done;
    @(posedge clk); #1;
    din.valid = 1'b0;
    dout.ready = 1'b1;
    @(negedge clk);
    post_valid = dout.valid;
    if (header_ack) acks++;
    if (proto_err) perr_cnt++;
    @(negedge clk);
    if (proto_err) perr_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    len_cfg = 4;
    for (int i = 0; i < MAXH; i++) hdr_b[i] = 8'(8'hA0 + i);
    load_header();
    header_vld = 1'b1;
    din.valid = 1'b1; din.sop = 1'b1; din.eop = 1'b1; din.data = '0; din.empty = '0;
    dout.ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (dout.valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", dout.valid); end
    checks++; if (din.ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", din.ready); end
    checks++; if (header_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", header_ack); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_proto_err: got %b want 0", proto_err); end
    @(posedge clk); #1;
    rst = 1'b0; header_vld = 1'b0; din.valid = 1'b0;
    @(negedge clk);
    checks++; if (dout.valid !== 1'b0 || din.ready !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: got valid=%b ready=%b want 0 0", dout.valid, din.ready); end
  endtask

  task automatic test_directed();
    logic [31:0] ew[4][4];
    int en[4], elen[4], eplen[4], eempty[4];
    beat_t e;
    ew = '{'{32'hA0A1A2A3, 32'hA4A5A6A7, 32'h10111213, 32'h0},
           '{32'hA0A1A2A3, 32'hA4A51011, 32'h12131400, 32'h0},
           '{32'hA0A1A210, 32'h11121300, 32'h0,        32'h0},
           '{32'h10111213, 32'h14150000, 32'h0,        32'h0}};
    en = '{3, 3, 2, 2}; elen = '{8, 6, 3, 0}; eplen = '{4, 5, 4, 6}; eempty = '{0, 1, 1, 2};
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < MAXH; i++) hdr_b[i] = 8'(8'hA0 + i);
      len_cfg = elen[c];
      pay_q.delete();
      for (int i = 0; i < eplen[c]; i++) pay_q.push_back(8'(8'h10 + i));
      rdy_mode = 0; gap_mode = 0; force_sop_err = 0;
      run_packet();
      checks++; if (o_q.size() != en[c]) begin errors++; $display("FAIL dir%0d_beats: got %0d want %0d", c, o_q.size(), en[c]); end
      for (int b = 0; b < en[c]; b++) begin
        e = '{ew[c][b], b == 0, b == en[c] - 1, (b == en[c] - 1) ? 2'(eempty[c]) : 2'd0};
        checks++; if (b >= o_q.size() || o_q[b] !== e) begin
          errors++; $display("FAIL dir%0d_beat%0d: got %h want %h", c, b, o_q[b], e); end
      end
      checks++; if (acks != 1) begin errors++; $display("FAIL dir%0d_ack: got %0d want 1", c, acks); end
      checks++; if (first_cyc != 0) begin errors++; $display("FAIL dir%0d_latency: got %0d want 0", c, first_cyc); end
      checks++; if (post_valid !== 1'b0) begin errors++; $display("FAIL dir%0d_idle: got %b want 0", c, post_valid); end
      if (c == 2) begin
        checks++; if (o_inrdy.size() < 2 || o_inrdy[1] !== 1'b0) begin
          errors++; $display("FAIL dir2_flush_ready: got %b want 0", o_inrdy[1]); end
      end
    end
  endtask

  task automatic test_backpressure();
    int plen[3];
    plen = '{5, 8, 11};
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < MAXH; i++) hdr_b[i] = 8'(8'hA0 + i);
      len_cfg = 6;
      pay_q.delete();
      for (int i = 0; i < plen[t]; i++) pay_q.push_back(8'(8'h10 + i));
      rdy_mode = 1; gap_mode = 1; force_sop_err = 0;
      run_packet();
      build_exp();
      checks++; if (timed_out) begin errors++; $display("FAIL bp%0d_timeout: got 1 want 0", t); end
      checks++; if (o_q.size() != exp_q.size()) begin
        errors++; $display("FAIL bp%0d_beats: got %0d want %0d", t, o_q.size(), exp_q.size()); end
      for (int b = 0; b < exp_q.size(); b++) begin
        checks++; if (b >= o_q.size() || o_q[b] !== exp_q[b]) begin
          errors++; $display("FAIL bp%0d_beat%0d: got %h want %h", t, b, o_q[b], exp_q[b]); end
      end
      checks++; if (stall_viol != 0) begin errors++; $display("FAIL bp%0d_stable: got %0d changes want 0", t, stall_viol); end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      len_cfg = $urandom_range(0, 20);
      for (int i = 0; i < MAXH; i++) hdr_b[i] = 8'($urandom);
      pay_q.delete();
      for (int i = 0; i < int'($urandom_range(1, 13)); i++) pay_q.push_back(8'($urandom));
      rdy_mode = 2; gap_mode = 1; force_sop_err = 0;
      run_packet();
      build_exp();
      checks++; if (timed_out) begin errors++; $display("FAIL rnd%0d_timeout: got 1 want 0", it); end
      checks++; if (o_q.size() != exp_q.size()) begin
        errors++; $display("FAIL rnd%0d_beats: got %0d want %0d", it, o_q.size(), exp_q.size()); end
      for (int b = 0; b < exp_q.size(); b++) begin
        checks++; if (b >= o_q.size() || o_q[b] !== exp_q[b]) begin
          errors++; $display("FAIL rnd%0d_beat%0d: got %h want %h", it, b, o_q[b], exp_q[b]); end
      end
      checks++; if (stall_viol != 0) begin errors++; $display("FAIL rnd%0d_stable: got %0d want 0", it, stall_viol); end
      checks++; if (acks != 1) begin errors++; $display("FAIL rnd%0d_ack: got %0d want 1", it, acks); end
      checks++; if (perr_cnt != 0) begin errors++; $display("FAIL rnd%0d_proto: got %0d want 0", it, perr_cnt); end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < MAXH; i++) hdr_b[i] = 8'(8'hA0 + i);
    len_cfg = 2;
    @(posedge clk); #1;
    load_header();
    header_vld = 1'b1; din.valid = 1'b0; dout.ready = 1'b1;
    @(posedge clk); #1;
    header_vld = 1'b0;
    din.valid = 1'b1; din.sop = 1'b1; din.eop = 1'b0; din.data = 32'h01020304; din.empty = 2'd0;
    @(negedge clk);
    checks++; if (dout.valid !== 1'b1 || dout.data !== 32'hA0A10102) begin
      errors++; $display("FAIL mid_merge: got v=%b %h want v=1 a0a10102", dout.valid, dout.data); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (dout.valid !== 1'b0 || din.ready !== 1'b0) begin
      errors++; $display("FAIL mid_rst: got v=%b r=%b want 0 0", dout.valid, din.ready); end
    @(posedge clk); #1;
    rst = 1'b0; din.valid = 1'b0;
    @(negedge clk);
    checks++; if (dout.valid !== 1'b0) begin errors++; $display("FAIL mid_idle: got %b want 0", dout.valid); end
    len_cfg = 4;
    pay_q.delete();
    for (int i = 0; i < 6; i++) pay_q.push_back(8'(8'h30 + i));
    rdy_mode = 0; gap_mode = 0; force_sop_err = 0;
    run_packet();
    build_exp();
    checks++; if (o_q.size() != exp_q.size()) begin
      errors++; $display("FAIL mid_next_beats: got %0d want %0d", o_q.size(), exp_q.size()); end
    for (int b = 0; b < exp_q.size(); b++) begin
      checks++; if (b >= o_q.size() || o_q[b] !== exp_q[b]) begin
        errors++; $display("FAIL mid_next_beat%0d: got %h want %h", b, o_q[b], exp_q[b]); end
    end
  endtask

  task automatic test_proto();
    int want;
`ifdef HEADER_INSERTER_PROTO_CHK_EN
    want = 1;
`else
    want = 0;
`endif
    for (int i = 0; i < MAXH; i++) hdr_b[i] = 8'(8'hB0 + i);
    len_cfg = 5;
    pay_q.delete();
    for (int i = 0; i < 9; i++) pay_q.push_back(8'(8'h40 + i));
    rdy_mode = 0; gap_mode = 0; force_sop_err = 1;
    run_packet();
    build_exp();
    force_sop_err = 0;
    checks++; if (perr_cnt != want) begin errors++; $display("FAIL proto_pulses: got %0d want %0d", perr_cnt, want); end
    checks++; if (o_q.size() != exp_q.size()) begin
      errors++; $display("FAIL proto_beats: got %0d want %0d", o_q.size(), exp_q.size()); end
    for (int b = 0; b < exp_q.size(); b++) begin
      checks++; if (b >= o_q.size() || o_q[b] !== exp_q[b]) begin
        errors++; $display("FAIL proto_beat%0d: got %h want %h", b, o_q[b], exp_q[b]); end
    end
  endtask

  initial begin
    force_sop_err = 0;
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_proto();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
